cpu_slave_term: RTL and testbench

CPU_SLAVE_TERM -- requirements
Module: cpu_slave_term

---
 rtl/cpu_sm_pkg.sv | 16 +
 rtl/sync2.sv | 25 ++
 rtl/cpu_slave_term.sv | 158 +++++++++++++++
 tb/tb_cpu_slave_term.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sm_pkg.sv
// Shared definitions for the 68030 slave termination controller:
// FSM state encoding and DSACK_ port-size codes.
package cpu_sm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_TERM   = 3'd2,
        ST_BERR   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_NONE = 2'b11;

endpackage

// File: rtl/sync2.sv
// Reusable two-flop synchronizer; both stages reset to 1 (inactive for
// active-low strobes).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/cpu_slave_term.sv
// 68030 slave bus-cycle terminator: issues register strobes and terminates
// the cycle with DSACK_, STERM_ or BERR_ after wait states / timeout.
module cpu_slave_term
    import cpu_sm_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic       SCLK,
    input  logic       RST,
    input  logic       AS_,
    input  logic       CS,
    input  logic       R_W,
    input  logic       SYNC_MODE,
    input  logic       REG_ACK,
    output logic       REG_RD,
    output logic       REG_WR,
    output logic [1:0] DSACK_,
    output logic       STERM_,
    output logic       BERR_,
    output logic       DOE
);

    localparam int unsigned WAIT_W = $clog2(WAIT_STATES + 2);
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic              as_s;
    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic              sync_q, sync_d;
    logic              ack_q, ack_d;
    logic              armed_q, armed_d;
    logic [1:0]        prime_q, prime_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              reg_rd_q, reg_rd_d;
    logic              reg_wr_q, reg_wr_d;
    logic [1:0]        dsack_q, dsack_d;
    logic              sterm_q, sterm_d;
    logic              berr_q, berr_d;
    logic              doe_q, doe_d;

    logic              start;
    logic              ack_ok;
    logic              timed_out;
    logic [WAIT_W:0]   wait_plus;

    sync2 u_as_sync (
        .clk (SCLK),
        .rst (RST),
        .d   (AS_),
        .q   (as_s)
    );

    // armed only after a genuine high AS_ has passed the synchronizer
    assign start     = (state_q == ST_IDLE) && armed_q && !as_s && CS;
    assign wait_plus = {1'b0, wait_cnt_q} + (WAIT_W + 1)'(1);
    assign ack_ok    = (ack_q || REG_ACK) && (wait_plus >= (WAIT_W + 1)'(WAIT_STATES));
    assign timed_out = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort beats ack, ack beats timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (as_s)           state_d = ST_IDLE;
                else if (ack_ok)    state_d = ST_TERM;
                else if (timed_out) state_d = ST_BERR;
            end
            ST_TERM: begin
                if (sync_q)    state_d = ST_HOLD;
                else if (as_s) state_d = ST_IDLE;
            end
            ST_HOLD,
            ST_BERR:   if (as_s) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rw_d       = rw_q;
        sync_d     = sync_q;
        ack_d      = ack_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        prime_d    = {prime_q[0], 1'b1};
        armed_d    = armed_q || (as_s && prime_q[1]);

        if (start) begin
            rw_d       = R_W;
            ack_d      = 1'b0;
            armed_d    = 1'b0;
            wait_cnt_d = '0;
            to_cnt_d   = '0;
        end

        if (state_q == ST_ACCESS) begin
            ack_d = ack_q || REG_ACK;
            if (wait_cnt_q < WAIT_W'(WAIT_STATES)) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (!timed_out)                        to_cnt_d   = to_cnt_q + TO_W'(1);
            if (state_d == ST_TERM)                sync_d     = SYNC_MODE;
        end

        // Outputs registered from the next state so they align with it
        reg_rd_d = start && R_W;
        reg_wr_d = start && !R_W;
        dsack_d  = ((state_d == ST_TERM) && !sync_d) ? DSACK_32 : DSACK_NONE;
        sterm_d  = !((state_d == ST_TERM) && sync_d);
        berr_d   = (state_d != ST_BERR);
        doe_d    = rw_d && (state_d inside {ST_ACCESS, ST_TERM, ST_HOLD});
    end

    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            rw_q       <= 1'b0;
            sync_q     <= 1'b0;
            ack_q      <= 1'b0;
            armed_q    <= 1'b0;
            prime_q    <= 2'b00;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            reg_rd_q   <= 1'b0;
            reg_wr_q   <= 1'b0;
            dsack_q    <= DSACK_NONE;
            sterm_q    <= 1'b1;
            berr_q     <= 1'b1;
            doe_q      <= 1'b0;
        end else begin
            rw_q       <= rw_d;
            sync_q     <= sync_d;
            ack_q      <= ack_d;
            armed_q    <= armed_d;
            prime_q    <= prime_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            reg_rd_q   <= reg_rd_d;
            reg_wr_q   <= reg_wr_d;
            dsack_q    <= dsack_d;
            sterm_q    <= sterm_d;
            berr_q     <= berr_d;
            doe_q      <= doe_d;
        end
    end

    assign REG_RD = reg_rd_q;
    assign REG_WR = reg_wr_q;
    assign DSACK_ = dsack_q;
    assign STERM_ = sterm_q;
    assign BERR_  = berr_q;
    assign DOE    = doe_q;

endmodule

// File: tb/tb_cpu_slave_term.sv
// Bench for cpu_slave_term: table of directed bus cycles, random cycles
// against an event-time model, and reset / chip-select corner sequences.
module tb_cpu_slave_term;
    import cpu_sm_pkg::*;

    localparam int WS = 2;
    localparam int TO = 64;
    localparam int K_NONE = 0, K_DSACK = 1, K_STERM = 2, K_BERR = 3;
    localparam int NO_ACK = 1000;

    logic       SCLK = 1'b0;
    logic       RST, AS_, CS, R_W, SYNC_MODE, REG_ACK;
    logic       REG_RD, REG_WR, STERM_, BERR_, DOE;
    logic [1:0] DSACK_;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] ds;
        logic       st;
        logic       be;
        logic       doe;
    } outv_t;

    typedef struct {
        bit rw;
        bit sm;
        int a;
        int b;
        int kind;
        int t;
    } vec_t;

    localparam outv_t IDLE_OUT = '{rd: 1'b0, wr: 1'b0, ds: 2'b11, st: 1'b1, be: 1'b1, doe: 1'b0};

    int n_chk  = 0;
    int n_fail = 0;

    cpu_slave_term #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .SCLK      (SCLK),
        .RST       (RST),
        .AS_       (AS_),
        .CS        (CS),
        .R_W       (R_W),
        .SYNC_MODE (SYNC_MODE),
        .REG_ACK   (REG_ACK),
        .REG_RD    (REG_RD),
        .REG_WR    (REG_WR),
        .DSACK_    (DSACK_),
        .STERM_    (STERM_),
        .BERR_     (BERR_),
        .DOE       (DOE)
    );

    always #5 SCLK = ~SCLK;

    task automatic cyc();
        @(posedge SCLK);
        #1;
    endtask

    function automatic outv_t sample();
        outv_t o;
        o.rd  = REG_RD;
        o.wr  = REG_WR;
        o.ds  = DSACK_;
        o.st  = STERM_;
        o.be  = BERR_;
        o.doe = DOE;
        return o;
    endfunction

    task automatic chk(input string name, input int idx, input outv_t act, input outv_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d got rd/wr/ds/st/be/doe=%b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Event-time model. Index 0 = strobe cycle; ack seen in cycle a, AS_
    // negated during cycle b (visible to the FSM two cycles later).
    function automatic void plan(input bit sm, input int a, input int b,
                                 output int kind, output int t, output int endi);
        t = (a + 1 > WS) ? a + 1 : WS;
        if (t > TO) begin
            kind = K_BERR;
            t    = TO;
        end else begin
            kind = sm ? K_STERM : K_DSACK;
        end
        if (b + 3 <= t) begin
            kind = K_NONE;
            t    = 0;
            endi = b + 3;
        end else if (kind == K_STERM) begin
            endi = (t + 2 > b + 3) ? t + 2 : b + 3;
        end else begin
            endi = (t + 1 > b + 3) ? t + 1 : b + 3;
        end
    endfunction

    function automatic outv_t expect_at(input bit rw, input bit sm, input int a, input int b, input int i);
        outv_t o;
        int kind, t, endi;
        plan(sm, a, b, kind, t, endi);
        o     = IDLE_OUT;
        o.rd  = (i == 0) && rw;
        o.wr  = (i == 0) && !rw;
        o.doe = rw && (i < ((kind == K_BERR) ? t : endi));
        if (kind == K_DSACK && i >= t && i < endi) o.ds = DSACK_32;
        if (kind == K_STERM && i == t)             o.st = 1'b0;
        if (kind == K_BERR && i >= t && i < endi)  o.be = 1'b0;
        return o;
    endfunction

    task automatic run_txn(input string name, input bit rw, input bit sm, input int a, input int b,
                           output int kind_o, output int t_o);
        outv_t act;
        int kind, t, endi;
        plan(sm, a, b, kind, t, endi);
        kind_o  = K_NONE;
        t_o     = 0;
        AS_     = 1'b1;
        CS      = 1'b0;
        REG_ACK = 1'b0;
        repeat (4) cyc();
        AS_       = 1'b0;
        CS        = 1'b1;
        R_W       = rw;
        SYNC_MODE = sm;
        for (int p = 0; p < 2; p++) begin
            cyc();
            chk({name, "_pre"}, p - 2, sample(), IDLE_OUT);
        end
        for (int i = 0; i <= b + 6; i++) begin
            cyc();
            act = sample();
            chk(name, i, act, expect_at(rw, sm, a, b, i));
            if (kind_o == K_NONE) begin
                if (act.ds == DSACK_32)  begin kind_o = K_DSACK; t_o = i; end
                else if (act.st == 1'b0) begin kind_o = K_STERM; t_o = i; end
                else if (act.be == 1'b0) begin kind_o = K_BERR;  t_o = i; end
            end
            REG_ACK = (i == a);
            if (i == b) AS_ = 1'b1;
            if (i >= 0) begin
                R_W = 1'($urandom);
                CS  = 1'($urandom);
            end
            if (kind != K_NONE && i >= t) SYNC_MODE = 1'($urandom);
        end
        AS_     = 1'b1;
        REG_ACK = 1'b0;
    endtask

    initial begin
        vec_t tbl[11];
        int   kind, t;
        outv_t act;

        tbl[0]  = '{rw: 1, sm: 0, a: 1,      b: 5,  kind: K_DSACK, t: 2};
        tbl[1]  = '{rw: 0, sm: 1, a: 0,      b: 5,  kind: K_STERM, t: 2};
        tbl[2]  = '{rw: 1, sm: 0, a: NO_ACK, b: 70, kind: K_BERR,  t: 64};
        tbl[3]  = '{rw: 1, sm: 0, a: 5,      b: 1,  kind: K_NONE,  t: 0};
        tbl[4]  = '{rw: 1, sm: 0, a: 63,     b: 70, kind: K_DSACK, t: 64};
        tbl[5]  = '{rw: 0, sm: 1, a: 63,     b: 70, kind: K_STERM, t: 64};
        tbl[6]  = '{rw: 0, sm: 1, a: 4,      b: 4,  kind: K_STERM, t: 5};
        tbl[7]  = '{rw: 1, sm: 0, a: 64,     b: 70, kind: K_BERR,  t: 64};
        tbl[8]  = '{rw: 0, sm: 0, a: 3,      b: 1,  kind: K_NONE,  t: 0};
        tbl[9]  = '{rw: 1, sm: 0, a: 1,      b: 0,  kind: K_DSACK, t: 2};
        tbl[10] = '{rw: 1, sm: 1, a: NO_ACK, b: 70, kind: K_BERR,  t: 64};

        RST = 1'b1; AS_ = 1'b1; CS = 1'b0; R_W = 1'b0; SYNC_MODE = 1'b0; REG_ACK = 1'b0;
        #12;
        chk("reset_state", 0, sample(), IDLE_OUT);
        RST = 1'b0;
        repeat (5) cyc();
        chk("post_reset_idle", 0, sample(), IDLE_OUT);

        foreach (tbl[k]) begin
            run_txn($sformatf("vec%0d", k), tbl[k].rw, tbl[k].sm, tbl[k].a, tbl[k].b, kind, t);
            chk_int($sformatf("vec%0d_kind", k), kind, tbl[k].kind);
            chk_int($sformatf("vec%0d_tidx", k), t, tbl[k].t);
        end

        for (int r = 0; r < 40; r++) begin
            int a, b;
            a = ($urandom_range(0, 3) == 0) ? NO_ACK : int'($urandom_range(0, 70));
            b = int'($urandom_range(0, 72));
            run_txn($sformatf("rnd%0d", r), 1'($urandom), 1'($urandom), a, b, kind, t);
        end

        // Chip-select low: no cycle starts, stray REG_ACK ignored
        repeat (4) cyc();
        AS_ = 1'b0; CS = 1'b0;
        for (int i = 0; i < 8; i++) begin
            REG_ACK = 1'($urandom);
            cyc();
            chk("cs_low", i, sample(), IDLE_OUT);
        end
        AS_ = 1'b1; REG_ACK = 1'b0;

        // Reset while DSACK_ asserted, AS_ held low across release
        repeat (4) cyc();
        AS_ = 1'b0; CS = 1'b1; R_W = 1'b1; SYNC_MODE = 1'b0;
        repeat (2) cyc();
        cyc();
        REG_ACK = 1'b1;
        cyc();
        REG_ACK = 1'b0;
        cyc();
        act = sample();
        chk_int("rst_pre_dsack", int'(act.ds), int'(DSACK_32));
        #2 RST = 1'b1;
        #1 chk("rst_async", 0, sample(), IDLE_OUT);
        cyc();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("rst_no_restart", i, sample(), IDLE_OUT);
        end
        AS_ = 1'b1;
        repeat (4) cyc();
        AS_ = 1'b0;
        repeat (2) cyc();
        cyc();
        chk("rst_fresh_strobe", 0, sample(), expect_at(1'b1, 1'b0, NO_ACK, 70, 0));
        AS_ = 1'b1;
        repeat (8) cyc();
        chk("rst_fresh_abort", 0, sample(), IDLE_OUT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
